// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: round-robin owner scheduler driving the select of a shared 16:1 mux.
// Define MUX_SCHED_TIMEOUT_EN to add a forced release after HOLD_LIMIT cycles of ownership.
module mux16_rr_sched #(
  parameter int HOLD_LIMIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic [15:0] grant,
  output logic        gnt_valid,
  output logic        busy,
  output logic        timeout
);
  typedef enum logic {IDLE, OWN} state_t;
  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d, last_q, last_d, win;
  logic [15:0] grant_q, grant_d;
  logic        gnt_valid_q, gnt_valid_d, busy_q, busy_d;
  logic        to_hit, rel, take;

  // Search last+1 .. last+16; the final candidate is last itself, so a lone owner is re-granted.
  always_comb begin
    win = last_q;
    for (int k = 15; k >= 0; k--)
      if (req[last_q + 4'(k + 1)]) win = last_q + 4'(k + 1);
  end

  always_comb begin
    rel         = done | ~req[sel_q] | to_hit;
    take        = |req && (state_q == IDLE || rel);
    state_d     = (take || (state_q == OWN && !rel)) ? OWN : IDLE;
    sel_d       = take ? win : sel_q;
    last_d      = take ? win : last_q;
    grant_d     = take ? 16'h1 << win : (state_d == OWN) ? grant_q : 16'h0;
    gnt_valid_d = state_d == OWN;
    busy_d      = state_d == OWN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 4'h0;
      last_q      <= 4'hF;
      grant_q     <= 16'h0;
      gnt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      grant_q     <= grant_d;
      gnt_valid_q <= gnt_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef MUX_SCHED_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  // done at the limit wins over the forced release, so no pulse in that case
  assign to_hit = state_q == OWN && cnt_q == 8'(HOLD_LIMIT - 1) && !done;
  always_comb begin
    cnt_d     = take ? 8'h0 : (state_q == OWN) ? cnt_q + 8'h1 : cnt_q;
    timeout_d = to_hit;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 8'h0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign gnt_valid = gnt_valid_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb_mux16_rr_sched: directed vectors with a queued expectation per cycle, checked by a separate monitor.
module tb_mux16_rr_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] req = 16'h0;
  logic        done = 1'b0;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        gnt_valid, busy, timeout;

  typedef struct {
    logic [22:0] v;
    int          id;
  } exp_t;
  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_step = 0;

  mux16_rr_sched #(.HOLD_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel(sel), .grant(grant), .gnt_valid(gnt_valid), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] pack(input logic [3:0] s, input logic v, input logic b, input logic t);
    logic [15:0] g;
    g = v ? (16'h1 << s) : 16'h0;
    return {s, g, v, b, t};
  endfunction

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got sel=%h grant=%h v/b/t=%b required sel=%h grant=%h v/b/t=%b",
               name, act[22:19], act[18:3], act[2:0], exp[22:19], exp[18:3], exp[2:0]);
    end
  endtask

  // drive inputs for the next edge and queue the outputs that edge must produce
  task automatic step(input logic [15:0] r, input logic d, input logic [3:0] s, input logic v, input logic t = 1'b0);
    exp_t e;
    @(negedge clk);
    req  = r;
    done = d;
    e.v  = pack(s, v, v, t);
    e.id = n_step++;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check($sformatf("step%0d", e.id), {sel, grant, gnt_valid, busy, timeout}, e.v);
      end
    end
  end

  logic to_on;
  initial begin
`ifdef MUX_SCHED_TIMEOUT_EN
    to_on = 1'b1;
`else
    to_on = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1 check("reset_init", {sel, grant, gnt_valid, busy, timeout}, pack(4'd0, 1'b0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(16'h0020, 1'b0, 4'd5, 1'b1);
    step(16'h0020, 1'b0, 4'd5, 1'b1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("reset_async", {sel, grant, gnt_valid, busy, timeout}, pack(4'd0, 1'b0, 1'b0, 1'b0));
    @(negedge clk) rst_n = 1'b1;
    step(16'h0001, 1'b0, 4'd0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      step(16'hFFFF, 1'b0, 4'(k), 1'b1);
      step(16'hFFFF, 1'b0, 4'(k), 1'b1);
      step(16'hFFFF, 1'b1, 4'(k + 1), 1'b1);
    end
    step(16'h4000, 1'b1, 4'd14, 1'b1);
    step(16'h4009, 1'b1, 4'd0, 1'b1);
    step(16'h4009, 1'b1, 4'd3, 1'b1);
    step(16'h4009, 1'b1, 4'd14, 1'b1);
    step(16'h4009, 1'b1, 4'd0, 1'b1);
    step(16'h0080, 1'b1, 4'd7, 1'b1);
    step(16'h0000, 1'b0, 4'd7, 1'b0);
    step(16'h0000, 1'b0, 4'd7, 1'b0);
    step(16'h0080, 1'b0, 4'd7, 1'b1);
    step(16'h0004, 1'b0, 4'd2, 1'b1);
    step(16'h0000, 1'b0, 4'd2, 1'b0);
    step(16'h0000, 1'b1, 4'd2, 1'b0);
    step(16'h0100, 1'b1, 4'd8, 1'b1);
    for (int k = 0; k < 4; k++) step(16'h0100, 1'b1, 4'd8, 1'b1);
    step(16'h0101, 1'b1, 4'd0, 1'b1);
    step(16'h0101, 1'b1, 4'd8, 1'b1);
    step(16'h0000, 1'b0, 4'd8, 1'b0);
    step(16'h0003, 1'b0, 4'd0, 1'b1);
    step(16'h0003, 1'b0, 4'd0, 1'b1);
    step(16'h0003, 1'b0, 4'd0, 1'b1);
    step(16'h0003, 1'b0, 4'd0, 1'b1);
    step(16'h0003, 1'b0, to_on ? 4'd1 : 4'd0, 1'b1, to_on);
    step(16'h0003, 1'b0, to_on ? 4'd1 : 4'd0, 1'b1);
    step(16'h0003, 1'b0, to_on ? 4'd1 : 4'd0, 1'b1);
    step(16'h0003, 1'b0, to_on ? 4'd1 : 4'd0, 1'b1);
    step(16'h0003, 1'b1, to_on ? 4'd0 : 4'd1, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
